// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the multiply-accumulate sequencer: state encoding
// and pipeline depth between operand capture and accumulator update.
package mac_sequencer_pkg;

   // Default width of the job length / remaining-pair counter.
   localparam int CNT_W_DEFAULT = 4;

   // Operand capture -> product register -> accumulator register.
   localparam int PIPE_DEPTH = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mac_sequencer_down_counter.sv
// Remaining-pair counter: loads the job length, counts accepted pairs down
// and saturates at zero so it can never wrap.
module mac_sequencer_down_counter #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero,
   output logic             o_one
);

   logic [CNT_W-1:0] r_count;

   // Load has priority; decrement only while pairs remain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);
   assign o_one  = (r_count == CNT_W'(1));

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM for the multiply-accumulate datapath. Accepts a job of N
// operand pairs via valid/ready, tracks them through the product and
// accumulator stages, and raises a held result handshake once the last
// product has landed in the accumulator.
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_en_op,
   output logic             o_en_prod,
   output logic             o_en_acc,
   output logic             o_acc_clr,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy
);

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_acc_clr;
   logic                  r_out_valid;
   logic                  r_busy;
   logic [PIPE_DEPTH-1:0] r_pipe_v;

   logic w_transfer;
   logic w_load;
   logic w_rem_zero;
   logic w_rem_one;
   logic w_pipe_empty_next;

   // A pair moves only when the controller is ready and the source is valid.
   assign w_transfer = r_in_ready & i_in_valid;

   // Length is captured only when a start arrives in IDLE; starts while busy
   // never reach the counter.
   assign w_load = (r_state == S_IDLE) & i_start;

   // In DRAIN nothing new enters, so the pipe is empty after the coming edge
   // once every stage except the last is already clear. Leaving DRAIN on that
   // condition makes out_valid coincide with the accumulator holding the
   // final sum.
   assign w_pipe_empty_next = (r_pipe_v[PIPE_DEPTH-2:0] == '0);

   mac_sequencer_down_counter #(
      .CNT_W(CNT_W)
   ) u_rem (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (i_len),
      .i_dec      (w_transfer),
      .o_zero     (w_rem_zero),
      .o_one      (w_rem_one)
   );

   // Valid-bit shift register shadowing the datapath pipeline; stall bubbles
   // travel through unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pipe_v <= '0;
      end else begin
         r_pipe_v <= {r_pipe_v[PIPE_DEPTH-2:0], w_transfer};
      end
   end

   // Job sequencing with outputs registered alongside the state transition.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_acc_clr   <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state   <= S_CLEAR;
                  r_acc_clr <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            S_CLEAR: begin
               r_acc_clr <= 1'b0;
               if (w_rem_zero) begin
                  // Empty job: the cleared accumulator is the result.
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b1;
               end
            end

            S_RUN: begin
               if (w_transfer && w_rem_one) begin
                  r_state    <= S_DRAIN;
                  r_in_ready <= 1'b0;
               end
            end

            S_DRAIN: begin
               if (w_pipe_empty_next) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end
            end

            S_DONE: begin
               if (i_out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_acc_clr   <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_en_op     = w_transfer;
   assign o_en_prod   = r_pipe_v[0];
   assign o_en_acc    = r_pipe_v[PIPE_DEPTH-1];
   assign o_acc_clr   = r_acc_clr;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: table of directed jobs with hand-derived pulse
// counts and completion cycles, a mid-job reset sequence, and random jobs
// checked cycle by cycle against a timeline model of the job rules.
module tb_mac_sequencer;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             out_ready;
   logic             in_ready;
   logic             en_op;
   logic             en_prod;
   logic             en_acc;
   logic             acc_clr;
   logic             out_valid;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_len       (len),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .o_en_op     (en_op),
      .o_en_prod   (en_prod),
      .o_en_acc    (en_acc),
      .o_acc_clr   (acc_clr),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_busy      (busy)
   );

   typedef struct {
      int          len;
      logic [63:0] mask;      // bit c = in_valid during job cycle c
      int          delay;     // cycles out_ready is held low in DONE
      int          exp_ops;
      int          exp_done;  // first cycle with out_valid high
   } vec_t;

   vec_t vecs[6];

   function automatic logic [6:0] outs();
      return {in_ready, en_op, en_prod, en_acc, acc_clr, out_valid, busy};
   endfunction

   function automatic logic valid_at(logic [63:0] m, int c);
      return (c < 64) ? m[c] : 1'b1;
   endfunction

   task automatic check7(string name, int cyc, logic [6:0] exp);
      logic [6:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d ir/op/prod/acc/clr/ov/busy got %b expected %b",
                  name, cyc, got, exp);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Runs one job starting from IDLE. Expected outputs come from a timeline:
   // pairs are accepted from cycle 2 while fewer than len have gone, product
   // and accumulator enables follow each acceptance by 1 and 2 cycles, and the
   // result is offered 3 cycles after the last acceptance (cycle 2 if empty).
   task automatic run_job(string name, int L, logic [63:0] mask, int delay,
                          output int n_ops, output int first_ov);
      bit         xf [0:255];
      bit         rdy[0:255];
      int         k;
      int         t_last;
      int         d_cyc;
      int         e_cyc;
      logic [6:0] e;
      for (int c = 0; c < 256; c++) begin
         xf[c]  = 1'b0;
         rdy[c] = 1'b0;
      end
      k = 0;
      t_last = -1;
      if (L > 0) begin
         for (int c = 2; k < L; c++) begin
            rdy[c] = 1'b1;
            if (valid_at(mask, c)) begin
               xf[c] = 1'b1;
               k++;
               t_last = c;
            end
         end
         d_cyc = t_last + 3;
      end else begin
         d_cyc = 2;
      end
      e_cyc = d_cyc + delay;
      n_ops = 0;
      first_ov = -1;
      for (int c = 0; c <= e_cyc + 1; c++) begin
         @(posedge clk);
         #1;
         if (c == 0)
            start = 1'b1;
         else if (c >= d_cyc && c <= e_cyc)
            start = 1'b1;
         else if (c <= e_cyc)
            start = 1'($urandom_range(0, 1));
         else
            start = 1'b0;
         len       = (c == 0) ? L[CNT_W-1:0] : CNT_W'($urandom_range(0, 15));
         in_valid  = valid_at(mask, c);
         out_ready = (c < d_cyc) ? 1'($urandom_range(0, 1)) : (c == e_cyc);
         #1;
         e = {rdy[c], xf[c],
              (c >= 1) ? xf[c-1] : 1'b0,
              (c >= 2) ? xf[c-2] : 1'b0,
              (c == 1),
              (c >= d_cyc && c <= e_cyc),
              (c >= 1 && c <= e_cyc)};
         check7(name, c, e);
         if (en_op) n_ops++;
         if (out_valid && first_ov < 0) first_ov = c;
      end
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int n_ops;
      int first_ov;
      logic [63:0] rmask;

      vecs[0] = '{3,  64'hFFFF_FFFF_FFFF_FFFF, 0, 3,  7};   // continuous stream
      vecs[1] = '{4,  64'hFFFF_FFFF_FFFF_FFB4, 0, 4,  10};  // valid 1,0,1,1,0,1
      vecs[2] = '{0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 0,  2};   // empty job
      vecs[3] = '{2,  64'hFFFF_FFFF_FFFF_FFFF, 5, 2,  6};   // consumer back-pressure
      vecs[4] = '{15, 64'hFFFF_FFFF_FFFF_FFFF, 0, 15, 19};  // maximum length
      vecs[5] = '{1,  64'h0000_0000_0000_0100, 2, 1,  11};  // long stall

      rst = 1'b1;
      start = 1'b0;
      len = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check7("reset", 0, 7'b0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_job($sformatf("vec%0d", i), vecs[i].len, vecs[i].mask, vecs[i].delay,
                 n_ops, first_ov);
         check_int($sformatf("vec%0d_ops", i), n_ops, vecs[i].exp_ops);
         check_int($sformatf("vec%0d_done", i), first_ov, vecs[i].exp_done);
      end

      // Reset in the middle of RUN with five pairs still outstanding.
      @(posedge clk); #1;
      start = 1'b1; len = 4'd8; in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         #1;
         check_int($sformatf("midrst_en_op_c%0d", c), int'(en_op), 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      check7("midrst_run", 5, 7'b1011001);
      rst = 1'b1;
      #1;
      check7("midrst_async", 5, 7'b0);
      @(posedge clk); #2;
      check7("midrst_next", 6, 7'b0);
      rst = 1'b0;

      run_job("post_rst", 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, n_ops, first_ov);
      check_int("post_rst_ops", n_ops, 2);
      check_int("post_rst_done", first_ov, 6);

      for (int j = 0; j < 25; j++) begin
         rmask = {$urandom, $urandom} | {$urandom, $urandom};
         run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 15)), rmask,
                 int'($urandom_range(0, 6)), n_ops, first_ov);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
